// File: rtl/pad_ring_ctrl.sv
// pad_ring_ctrl
//   Pad-ring control block sitting between the pad ring and the core logic.
//   Per-pad configuration (IE, PU, PD, CS, SL, output/OE override) is
//   written into shadow registers through a valid/ready request/response
//   port and copied to the active registers, which drive the pads, by a
//   COMMIT write. All pad-to-core inputs pass through a flop synchroniser.
//
//   Optional build macro: PAD_RING_CTRL_LOCK_EN
//     Defined   -> a LOCK register at address 2^ADDR_W-2; writing 0xA5 sets
//                  a sticky lock that blocks every later write until rst.
//     Undefined -> the LOCK address is unmapped and no lock bit exists.
//
//   Request/response handshake:
//     A request is accepted on a clk edge where req_valid && req_ready.
//     req_ready is high only while the FSM is idle. The response appears on
//     the following cycle with rsp_valid=1 and holds rsp_rdata/rsp_err
//     stable until the clk edge where rsp_valid && rsp_ready, after which
//     the block is idle again. rst drops any pending response.
//
//   Address map:
//     0 .. NB-1            bidir pad config
//                          [0] ie [1] pu [2] pd [3] cs [4] sl
//                          [5] ovr_en [6] ovr_out [7] ovr_oe
//     NB .. NB+NI-1        input pad config ([1] pu [2] pd, rest read 0)
//     2^ADDR_W-2           LOCK (only with PAD_RING_CTRL_LOCK_EN)
//     2^ADDR_W-1           COMMIT (write copies shadow -> active, read 0)
//     anything else        unmapped, rsp_err=1, no state change
//
//   A write with pu=pd=1 is stored as pu=1, pd=0 so a pad is never pulled
//   both ways; the write still completes without error.
//
//   Parameter constraints: SYNC_STAGES in 2..4,
//   2^ADDR_W >= NUM_BIDIR_PADS + NUM_INPUT_PADS + 2.

module pad_ring_ctrl #(
  parameter int NUM_BIDIR_PADS = 40,
  parameter int NUM_INPUT_PADS = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int ADDR_W         = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  // configuration request/response port
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [7:0]                req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [7:0]                rsp_rdata,
  output logic                      rsp_err,
  // core side
  input  logic [NUM_BIDIR_PADS-1:0] core_out,
  input  logic [NUM_BIDIR_PADS-1:0] core_oe,
  output logic [NUM_BIDIR_PADS-1:0] core_bidir_in,
  output logic [NUM_INPUT_PADS-1:0] core_input_in,
  // bidir pads
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  // input-only pads
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd
);

  localparam int NB = NUM_BIDIR_PADS;
  localparam int NI = NUM_INPUT_PADS;

  localparam logic [ADDR_W-1:0] COMMIT_ADDR = '1;
  localparam logic [7:0]        BIDIR_RST   = 8'h01;

  // Bit positions inside a bidir config byte
  localparam int B_IE      = 0;
  localparam int B_PU      = 1;
  localparam int B_PD      = 2;
  localparam int B_CS      = 3;
  localparam int B_SL      = 4;
  localparam int B_OVR_EN  = 5;
  localparam int B_OVR_OUT = 6;
  localparam int B_OVR_OE  = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t state;

  // Shadow (programmed) and active (driving the pads) configuration.
  // Input pads only keep {pd, pu}.
  logic [NB-1:0][7:0] bidir_shadow;
  logic [NB-1:0][7:0] bidir_active;
  logic [NI-1:0][1:0] input_shadow;
  logic [NI-1:0][1:0] input_active;

  // Synchroniser chains, stage 0 is the first flop after the pad
  logic [SYNC_STAGES-1:0][NB-1:0] bidir_sync;
  logic [SYNC_STAGES-1:0][NI-1:0] input_sync;

  // Request decode
  logic       accept;
  logic       hit_bidir;
  logic       hit_input;
  logic       hit_commit;
  logic       hit_lock;
  logic       mapped;
  logic       locked;
  logic       acc_err;
  logic       do_write;
  logic [7:0] rd_data;
  logic [7:0] wr_bidir;
  logic [1:0] wr_input;

  assign accept = req_valid && req_ready;

  // Conflict rule: pu wins over pd when both are requested
  assign wr_bidir = {req_wdata[7:3], req_wdata[B_PD] & ~req_wdata[B_PU],
                     req_wdata[B_PU], req_wdata[B_IE]};
  assign wr_input = {req_wdata[B_PD] & ~req_wdata[B_PU], req_wdata[B_PU]};

`ifdef PAD_RING_CTRL_LOCK_EN
  localparam logic [ADDR_W-1:0] LOCK_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [7:0]        LOCK_KEY  = 8'hA5;

  logic lock;

  assign hit_lock = (req_addr == LOCK_ADDR);
  assign locked   = lock;

  // Sticky lock: set by the key write while unlocked, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      lock <= 1'b0;
    end else if (accept && req_we && hit_lock && !lock && (req_wdata == LOCK_KEY)) begin
      lock <= 1'b1;
    end
  end
`else
  assign hit_lock = 1'b0;
  assign locked   = 1'b0;
`endif

  // Address decode and shadow read mux
  always_comb begin
    hit_bidir = 1'b0;
    hit_input = 1'b0;
    rd_data   = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        hit_bidir = 1'b1;
        rd_data   = bidir_shadow[i];
      end
    end
    for (int j = 0; j < NI; j++) begin
      if (req_addr == ADDR_W'(NB + j)) begin
        hit_input = 1'b1;
        rd_data   = {5'b00000, input_shadow[j], 1'b0};
      end
    end
`ifdef PAD_RING_CTRL_LOCK_EN
    if (hit_lock) begin
      rd_data = {7'b0000000, lock};
    end
`endif
  end

  assign hit_commit = (req_addr == COMMIT_ADDR);
  assign mapped     = hit_bidir || hit_input || hit_commit || hit_lock;
  assign acc_err    = !mapped || (req_we && locked);
  assign do_write   = accept && req_we && !acc_err;

  // Request/response FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_RESP;
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= req_we ? 8'h00 : rd_data;
            rsp_err   <= acc_err;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 8'h00;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  // Shadow writes and atomic COMMIT copy of every shadow into active
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        bidir_shadow[i] <= BIDIR_RST;
        bidir_active[i] <= BIDIR_RST;
      end
      for (int j = 0; j < NI; j++) begin
        input_shadow[j] <= 2'b00;
        input_active[j] <= 2'b00;
      end
    end else if (do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (hit_bidir && (req_addr == ADDR_W'(i))) begin
          bidir_shadow[i] <= wr_bidir;
        end
      end
      for (int j = 0; j < NI; j++) begin
        if (hit_input && (req_addr == ADDR_W'(NB + j))) begin
          input_shadow[j] <= wr_input;
        end
      end
      if (hit_commit) begin
        bidir_active <= bidir_shadow;
        input_active <= input_shadow;
      end
    end
  end

  // Pad input synchronisers, shifting one stage per clk edge
  always_ff @(posedge clk) begin
    if (rst) begin
      bidir_sync <= '0;
      input_sync <= '0;
    end else begin
      bidir_sync <= {bidir_sync[SYNC_STAGES-2:0], bidir_in};
      input_sync <= {input_sync[SYNC_STAGES-2:0], input_in};
    end
  end

  // Pad control fan-out and output/OE override mux
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bidir_ie[i]      = bidir_active[i][B_IE];
      bidir_pu[i]      = bidir_active[i][B_PU];
      bidir_pd[i]      = bidir_active[i][B_PD];
      bidir_cs[i]      = bidir_active[i][B_CS];
      bidir_sl[i]      = bidir_active[i][B_SL];
      bidir_out[i]     = bidir_active[i][B_OVR_EN] ? bidir_active[i][B_OVR_OUT] : core_out[i];
      bidir_oe[i]      = bidir_active[i][B_OVR_EN] ? bidir_active[i][B_OVR_OE]  : core_oe[i];
      // A pad with its input buffer disabled reads as 0 in the core
      core_bidir_in[i] = bidir_sync[SYNC_STAGES-1][i] & bidir_active[i][B_IE];
    end
    for (int j = 0; j < NI; j++) begin
      input_pu[j] = input_active[j][0];
      input_pd[j] = input_active[j][1];
    end
  end

  assign core_input_in = input_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_pad_ring_ctrl.sv
// tb_pad_ring_ctrl
//   Bench for pad_ring_ctrl: directed scenarios followed by randomized
//   config traffic and random pad/core inputs, compared against a
//   register-file model with a history queue for the synchronisers.
//   Build with +define+PAD_RING_CTRL_LOCK_EN to include the lock scenarios.

module tb_pad_ring_ctrl;

  localparam int NB = 40;
  localparam int NI = 12;
  localparam int SS = 2;
  localparam int AW = 7;

  localparam logic [AW-1:0] COMMIT_A = 7'h7F;
  localparam logic [AW-1:0] LOCK_A   = 7'h7E;

`ifdef PAD_RING_CTRL_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_rdata;
  logic          rsp_err;
  logic [NB-1:0] core_out;
  logic [NB-1:0] core_oe;
  logic [NB-1:0] core_bidir_in;
  logic [NI-1:0] core_input_in;
  logic [NB-1:0] bidir_in;
  logic [NB-1:0] bidir_out;
  logic [NB-1:0] bidir_oe;
  logic [NB-1:0] bidir_cs;
  logic [NB-1:0] bidir_sl;
  logic [NB-1:0] bidir_ie;
  logic [NB-1:0] bidir_pu;
  logic [NB-1:0] bidir_pd;
  logic [NI-1:0] input_in;
  logic [NI-1:0] input_pu;
  logic [NI-1:0] input_pd;

  pad_ring_ctrl #(
    .NUM_BIDIR_PADS(NB),
    .NUM_INPUT_PADS(NI),
    .SYNC_STAGES   (SS),
    .ADDR_W        (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .core_out     (core_out),
    .core_oe      (core_oe),
    .core_bidir_in(core_bidir_in),
    .core_input_in(core_input_in),
    .bidir_in     (bidir_in),
    .bidir_out    (bidir_out),
    .bidir_oe     (bidir_oe),
    .bidir_cs     (bidir_cs),
    .bidir_sl     (bidir_sl),
    .bidir_ie     (bidir_ie),
    .bidir_pu     (bidir_pu),
    .bidir_pd     (bidir_pd),
    .input_in     (input_in),
    .input_pu     (input_pu),
    .input_pd     (input_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [8:0]    exp_q[$];       // expected {rsp_err, rsp_rdata} per accepted request
  logic [NB-1:0] hist_b[$];      // raw bidir_in sampled at each clk edge since reset
  logic [NI-1:0] hist_i[$];

  logic [7:0] m_sh_b[NB];
  logic [7:0] m_act_b[NB];
  logic [7:0] m_sh_i[NI];
  logic [7:0] m_act_i[NI];
  logic       m_lock;

  logic       chk_en  = 1'b0;
  logic       rand_en = 1'b0;
  logic [63:0] r64;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_sh_b[i]  = 8'h01;
      m_act_b[i] = 8'h01;
    end
    for (int j = 0; j < NI; j++) begin
      m_sh_i[j]  = 8'h00;
      m_act_i[j] = 8'h00;
    end
    m_lock = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_access(input logic we, input logic [AW-1:0] addr,
                                       input logic [7:0] wd);
    int         a;
    logic [7:0] v;
    logic [7:0] rd;
    logic       err;
    a   = int'(addr);
    rd  = 8'h00;
    err = 1'b0;
    v   = wd;
    if (v[1]) v[2] = 1'b0;
    if (a < NB) begin
      if (!we) rd = m_sh_b[a];
      else if (m_lock) err = 1'b1;
      else m_sh_b[a] = v;
    end else if (a < NB + NI) begin
      if (!we) rd = m_sh_i[a-NB];
      else if (m_lock) err = 1'b1;
      else m_sh_i[a-NB] = v & 8'h06;
    end else if (a == 2**AW - 1) begin
      if (we) begin
        if (m_lock) err = 1'b1;
        else begin
          m_act_b = m_sh_b;
          m_act_i = m_sh_i;
        end
      end
    end else if (LOCK_EN && a == 2**AW - 2) begin
      if (!we) rd = {7'b0000000, m_lock};
      else if (m_lock) err = 1'b1;
      else if (wd == 8'hA5) m_lock = 1'b1;
    end else begin
      err = 1'b1;
    end
    exp_q.push_back({err, rd});
  endfunction

  // Compare every pad-facing output against the active model and input history
  task automatic check_pads();
    logic [NB-1:0] e_ie, e_pu, e_pd, e_cs, e_sl, e_out, e_oe, e_cbi;
    logic [NI-1:0] e_ipu, e_ipd, e_cii;
    for (int i = 0; i < NB; i++) begin
      e_ie[i]  = m_act_b[i][0];
      e_pu[i]  = m_act_b[i][1];
      e_pd[i]  = m_act_b[i][2];
      e_cs[i]  = m_act_b[i][3];
      e_sl[i]  = m_act_b[i][4];
      e_out[i] = m_act_b[i][5] ? m_act_b[i][6] : core_out[i];
      e_oe[i]  = m_act_b[i][5] ? m_act_b[i][7] : core_oe[i];
    end
    for (int j = 0; j < NI; j++) begin
      e_ipu[j] = m_act_i[j][1];
      e_ipd[j] = m_act_i[j][2];
    end
    e_cbi = (hist_b.size() >= SS) ? hist_b[hist_b.size()-SS] : '0;
    e_cbi = e_cbi & e_ie;
    e_cii = (hist_i.size() >= SS) ? hist_i[hist_i.size()-SS] : '0;
    check("bidir_ie",      64'(bidir_ie),      64'(e_ie));
    check("bidir_pu",      64'(bidir_pu),      64'(e_pu));
    check("bidir_pd",      64'(bidir_pd),      64'(e_pd));
    check("bidir_cs",      64'(bidir_cs),      64'(e_cs));
    check("bidir_sl",      64'(bidir_sl),      64'(e_sl));
    check("bidir_out",     64'(bidir_out),     64'(e_out));
    check("bidir_oe",      64'(bidir_oe),      64'(e_oe));
    check("input_pu",      64'(input_pu),      64'(e_ipu));
    check("input_pd",      64'(input_pd),      64'(e_ipd));
    check("core_bidir_in", 64'(core_bidir_in), 64'(e_cbi));
    check("core_input_in", 64'(core_input_in), 64'(e_cii));
  endtask

  // Record raw pad inputs seen at each edge; reset empties the chain
  always @(posedge clk) begin
    if (rst) begin
      hist_b.delete();
      hist_i.delete();
    end else begin
      hist_b.push_back(bidir_in);
      hist_i.push_back(input_in);
      if (hist_b.size() > 8) void'(hist_b.pop_front());
      if (hist_i.size() > 8) void'(hist_i.pop_front());
    end
  end

  // Pad checker, just after each active edge
  always @(posedge clk) begin
    #2;
    if (chk_en) check_pads();
  end

  // Random pad/core input driver
  always @(negedge clk) begin
    if (rand_en) begin
      r64 = {$urandom(), $urandom()};
      core_out = r64[NB-1:0];
      r64 = {$urandom(), $urandom()};
      core_oe = r64[NB-1:0];
      r64 = {$urandom(), $urandom()};
      bidir_in = r64[NB-1:0];
      input_in = NI'($urandom());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      model_reset();
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [7:0] wd, input int hold);
    logic [8:0] e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = 1'b0;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    model_access(we, addr, wd);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = 8'h00;
    e = exp_q.pop_front();
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_payload", 64'({rsp_err, rsp_rdata}), 64'(e));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_payload", 64'({rsp_err, rsp_rdata}), 64'(e));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", 64'({rsp_valid, req_ready}), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a;
    logic          w;
    logic [7:0]    d;
    int            r;
    int            hold;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = 8'h00;
    rsp_ready = 1'b0;
    core_out  = '0;
    core_oe   = '0;
    bidir_in  = '0;
    input_in  = '0;
    model_reset();

    do_reset(2);
    chk_en = 1'b1;

    // Reset state
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    check("rst_ie_all", 64'(bidir_ie), 64'({NB{1'b1}}));
    do_req(1'b0, 7'd0, 8'h00, 0);

    // pu/pd conflict, commit timing, shadow read-back
    do_req(1'b1, 7'd3, 8'h07, 0);
    check("pu3_before_commit", 64'(bidir_pu[3]), 64'd0);
    do_req(1'b1, COMMIT_A, 8'h00, 0);
    check("pu3_after_commit", 64'(bidir_pu[3]), 64'd1);
    check("pd3_after_commit", 64'(bidir_pd[3]), 64'd0);
    do_req(1'b0, 7'd3, 8'h00, 0);

    // Output override and its release
    core_out[5] = 1'b0;
    core_oe[5]  = 1'b0;
    do_req(1'b1, 7'd5, 8'hE1, 0);
    do_req(1'b1, COMMIT_A, 8'h00, 0);
    check("ovr_out5", 64'(bidir_out[5]), 64'd1);
    check("ovr_oe5", 64'(bidir_oe[5]), 64'd1);
    do_req(1'b1, 7'd5, 8'h01, 0);
    do_req(1'b1, COMMIT_A, 8'h00, 0);
    core_out[5] = 1'b1;
    core_oe[5]  = 1'b0;
    #1;
    check("follow_out5", 64'(bidir_out[5]), 64'd1);
    check("follow_oe5", 64'(bidir_oe[5]), 64'd0);

    // Synchroniser latency on an input pad
    @(negedge clk);
    input_in[0] = 1'b1;
    for (int k = 1; k <= SS + 1; k++) begin
      @(posedge clk);
      #2;
      check("sync_rise", 64'(core_input_in[0]), (k >= SS) ? 64'd1 : 64'd0);
    end

    // ie=0 gates the bidir input to the core
    do_req(1'b1, 7'd2, 8'h00, 0);
    do_req(1'b1, COMMIT_A, 8'h00, 0);
    bidir_in[2] = 1'b1;
    bidir_in[5] = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #2;
    check("ie0_gate2", 64'(core_bidir_in[2]), 64'd0);
    check("ie1_pass5", 64'(core_bidir_in[5]), 64'd1);

    // Backpressure on a read, unmapped accesses
    do_req(1'b0, 7'd3, 8'h00, 5);
    do_req(1'b0, 7'd60, 8'h00, 0);
    do_req(1'b1, 7'd60, 8'hFF, 2);
    do_req(1'b0, COMMIT_A, 8'h00, 0);
    do_req(1'b0, LOCK_A, 8'h00, 0);
    do_req(1'b0, 7'd0, 8'h00, 0);
    do_req(1'b1, 7'(NB + 4), 8'h06, 0);
    do_req(1'b0, 7'(NB + 4), 8'h00, 0);
    do_req(1'b1, COMMIT_A, 8'h00, 0);
    check("input_pu4", 64'(input_pu[4]), 64'd1);

    // Reset in the middle of a transaction
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 7'd4;
    req_wdata = 8'h1E;
    @(posedge clk);
    model_access(1'b1, 7'd4, 8'h1E);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    do_req(1'b0, 7'd4, 8'h00, 0);
    do_req(1'b0, 7'd3, 8'h00, 0);

`ifdef PAD_RING_CTRL_LOCK_EN
    do_req(1'b1, LOCK_A, 8'h5A, 0);
    do_req(1'b0, LOCK_A, 8'h00, 0);
    do_req(1'b1, LOCK_A, 8'hA5, 0);
    do_req(1'b0, LOCK_A, 8'h00, 0);
    do_req(1'b1, 7'd0, 8'h00, 0);
    do_req(1'b0, 7'd0, 8'h00, 0);
    do_req(1'b1, COMMIT_A, 8'h00, 0);
    do_req(1'b1, LOCK_A, 8'hA5, 0);
    do_reset(1);
    do_req(1'b0, LOCK_A, 8'h00, 0);
    do_req(1'b1, 7'd0, 8'h00, 0);
    do_req(1'b0, 7'd0, 8'h00, 0);
`endif

    // Randomized traffic with random pad/core inputs
    rand_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      hold = $urandom_range(0, 3);
      if (r == 0) begin
        a = COMMIT_A;
        w = 1'b1;
      end else if (r == 1) begin
        a = AW'($urandom_range(NB + NI, 2**AW - 1));
      end else begin
        a = AW'($urandom_range(0, NB + NI - 1));
      end
      do_req(w, a, d, hold);
      if (n == 150) do_reset(1);
    end
    rand_en = 1'b0;

    @(negedge clk);
    chk_en = 1'b0;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_ring_ctrl.md
Name: pad_ring_ctrl

Overview:
- Parametrised pad-ring control block between the pad ring and the core logic.
- Holds per-pad configuration for every bidir and input pad: IE, PU, PD, CS, SL, and an output/OE override.
- Configuration is written to shadow registers over a valid/ready request/response port, then applied to all pads atomically by a COMMIT write.
- Synchronises all pad-to-core inputs with a configurable flop chain.

Parameters:
- NUM_BIDIR_PADS, 40, number of bidirectional pads.
- NUM_INPUT_PADS, 12, number of input-only pads.
- SYNC_STAGES, 2, synchroniser depth on pad inputs; legal range 2..4.
- ADDR_W, 7, config address width; must satisfy 2^ADDR_W >= NUM_BIDIR_PADS+NUM_INPUT_PADS+2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  config request valid.
- req_ready  out  1  block accepts the request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  config address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  8  read data; 0 for writes.
- rsp_err  out  1  access error.
- core_out  in  NUM_BIDIR_PADS  core output data.
- core_oe  in  NUM_BIDIR_PADS  core output enable.
- core_bidir_in  out  NUM_BIDIR_PADS  synchronised bidir pad input.
- core_input_in  out  NUM_INPUT_PADS  synchronised input pad value.
- bidir_in  in  NUM_BIDIR_PADS  raw pad Y.
- bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd  out  NUM_BIDIR_PADS each  to bidir pads.
- input_in  in  NUM_INPUT_PADS  raw pad Y.
- input_pu, input_pd  out  NUM_INPUT_PADS each  to input pads.

Behaviour:
- Address map:
  - 0..NUM_BIDIR_PADS-1: bidir config.
  - NUM_BIDIR_PADS..NUM_BIDIR_PADS+NUM_INPUT_PADS-1: input config.
  - 2^ADDR_W-1: COMMIT.
  - 2^ADDR_W-2: LOCK (see Optional Feature).
  - All other addresses are unmapped.
- Bidir config byte: [0] ie, [1] pu, [2] pd, [3] cs, [4] sl, [5] ovr_en, [6] ovr_out, [7] ovr_oe.
- Input config byte: [1] pu, [2] pd; all other bits read as 0.
- PU/PD conflict: a write with pu=pd=1 stores pu=1, pd=0. The write still succeeds with rsp_err=0.
- Reset values:
  - Shadow and active bidir configs = 0x01 (ie=1 only); input configs = 0x00.
  - FSM in IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
  - All synchroniser flops = 0.
- FSM: IDLE -> RESP on req_valid&&req_ready. RESP -> IDLE on rsp_ready. req_ready=1 only in IDLE.
- Accept cycle:
  - Write to a pad address updates that shadow register.
  - Read returns the shadow value (not the active value).
  - rsp_* are registered and valid the next cycle (1-cycle latency).
  - rsp_* hold stable while rsp_valid=1 && !rsp_ready.
- COMMIT write:
  - Copies all shadows to active registers in the accept cycle.
  - Pad control outputs change on the next clk edge, all pads simultaneously.
  - COMMIT read returns 0x00.
- Unmapped address, read or write: no state change; rsp_rdata=0; rsp_err=1.
- Pad control outputs: bidir_ie/cs/sl/pu/pd and input_pu/pd are driven directly from the active registers.
- Output path:
  - ovr_en=0: bidir_out=core_out, bidir_oe=core_oe (combinational).
  - ovr_en=1: bidir_out=ovr_out, bidir_oe=ovr_oe.
- Input synchronisers:
  - core_bidir_in and core_input_in follow the raw inputs after exactly SYNC_STAGES clk edges.
  - When bidir ie=0 (active), core_bidir_in is forced to 0 at the synchroniser output.
- Reset mid-transaction: rst aborts the transaction. Next cycle is IDLE, rsp_valid=0, all configs at reset values; no response is ever issued for the aborted request.

Optional Feature:
- Macro PAD_RING_CTRL_LOCK_EN.
- Defined:
  - A write of 0xA5 to LOCK sets a sticky lock bit, cleared only by rst.
  - While locked, every write (pad, COMMIT, LOCK) is ignored with rsp_err=1.
  - Reads still work; a LOCK read returns {7'b0, lock}.
  - A write of any other value to LOCK is ignored with rsp_err=0.
- Undefined: LOCK is an unmapped address (rsp_err=1); no lock bit exists.

Test Plan:
- Reset, then read addr 0 -> rsp_rdata=0x01, rsp_err=0; bidir_ie all ones, all bidir_pu/pd/cs/sl and input_pu/pd zero.
- Write addr 3=0x07, check bidir_pu[3]=0 before COMMIT; write COMMIT -> one cycle after its accept, bidir_pu[3]=1 and bidir_pd[3]=0 (conflict rule); read addr 3 returns 0x03.
- Write addr 5=0xE1 + COMMIT with core_out[5]=0, core_oe[5]=0 -> bidir_out[5]=1, bidir_oe[5]=1; write 0x01 + COMMIT -> follows core_out/core_oe again.
- Toggle input_in[0] 0->1 -> core_input_in[0] rises exactly SYNC_STAGES cycles later; with active ie=0 on bidir 2, bidir_in[2]=1 gives core_bidir_in[2]=0.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable, req_ready=0; access to addr 60 -> rsp_err=1, no state change.
- With PAD_RING_CTRL_LOCK_EN: write LOCK=0xA5, then write addr 0=0x00 -> rsp_err=1, read addr 0 still 0x01; assert rst -> lock cleared and writes succeed.
